// File: rtl/ecc_scalar_mult_ctrl.sv
// Scalar-multiplication controller for Q = k*P by left-to-right double-and-add,
// driving one shared external point engine with infinity tracking and optional dummy adds.
module ecc_scalar_mult_ctrl #(
    parameter int unsigned WIDTH      = 256,
    parameter int unsigned K_LEN0     = 64,
    parameter int unsigned K_LEN1     = 128,
    parameter int unsigned K_LEN2     = 192,
    parameter int unsigned K_LEN3     = 256,
    parameter bit          CONST_TIME = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_k,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_inf,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y,
    output logic             o_op_req,
    output logic             o_op_dbl,
    output logic [WIDTH-1:0] o_op_x1,
    output logic [WIDTH-1:0] o_op_y1,
    output logic [WIDTH-1:0] o_op_x2,
    output logic [WIDTH-1:0] o_op_y2,
    input  logic             i_op_done,
    input  logic [WIDTH-1:0] i_op_x,
    input  logic [WIDTH-1:0] i_op_y
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DBL,
        S_DBL_WAIT,
        S_BIT,
        S_ADD_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] k_q, k_d, px_q, px_d, py_q, py_d, rx_q, rx_d, ry_q, ry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             inf_q, inf_d, discard_q, discard_d;
    logic             req_q, req_d, dbl_q, dbl_d;
    logic [WIDTH-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    logic             done_q, done_d, oinf_q, oinf_d;
    logic [WIDTH-1:0] ox_q, ox_d, oy_q, oy_d;
    logic             advance;
    logic             kbit;

    function automatic logic [CW-1:0] top_bit(input logic [1:0] mode);
        case (mode)
            2'b00:   top_bit = CW'(K_LEN0 - 1);
            2'b01:   top_bit = CW'(K_LEN1 - 1);
            2'b10:   top_bit = CW'(K_LEN2 - 1);
            default: top_bit = CW'(K_LEN3 - 1);
        endcase
    endfunction

    assign kbit = k_q[cnt_q];

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        px_d      = px_q;
        py_d      = py_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        cnt_d     = cnt_q;
        inf_d     = inf_q;
        discard_d = discard_q;
        req_d     = 1'b0;
        dbl_d     = dbl_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        x2_d      = x2_q;
        y2_d      = y2_q;
        done_d    = 1'b0;
        oinf_d    = oinf_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        advance   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A start during the o_done cycle is still treated as busy.
                if (i_start && !done_q) begin
                    k_d     = i_k;
                    px_d    = i_x;
                    py_d    = i_y;
                    cnt_d   = top_bit(i_mode);
                    inf_d   = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (kbit) begin
                    rx_d    = px_q;
                    ry_d    = py_q;
                    inf_d   = 1'b0;
                    advance = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DBL: begin
                if (inf_q) begin
                    state_d = S_BIT;
                end else if (ry_q == '0) begin
                    inf_d   = 1'b1;
                    state_d = S_BIT;
                end else begin
                    req_d   = 1'b1;
                    dbl_d   = 1'b1;
                    x1_d    = rx_q;
                    y1_d    = ry_q;
                    state_d = S_DBL_WAIT;
                end
            end
            S_DBL_WAIT: begin
                if (i_op_done) begin
                    rx_d    = i_op_x;
                    ry_d    = i_op_y;
                    state_d = S_BIT;
                end
            end
            S_BIT: begin
                if (kbit) begin
                    if (inf_q) begin
                        rx_d    = px_q;
                        ry_d    = py_q;
                        inf_d   = 1'b0;
                        advance = 1'b1;
                    end else if (rx_q == px_q && ry_q == py_q) begin
                        req_d     = 1'b1;
                        dbl_d     = 1'b1;
                        x1_d      = px_q;
                        y1_d      = py_q;
                        discard_d = 1'b0;
                        state_d   = S_ADD_WAIT;
                    end else if (rx_q == px_q) begin
                        inf_d   = 1'b1;
                        advance = 1'b1;
                    end else begin
                        req_d     = 1'b1;
                        dbl_d     = 1'b0;
                        x1_d      = rx_q;
                        y1_d      = ry_q;
                        x2_d      = px_q;
                        y2_d      = py_q;
                        discard_d = 1'b0;
                        state_d   = S_ADD_WAIT;
                    end
                end else if (CONST_TIME) begin
                    req_d     = 1'b1;
                    dbl_d     = 1'b0;
                    x1_d      = rx_q;
                    y1_d      = ry_q;
                    x2_d      = px_q;
                    y2_d      = py_q;
                    discard_d = 1'b1;
                    state_d   = S_ADD_WAIT;
                end else begin
                    advance = 1'b1;
                end
            end
            S_ADD_WAIT: begin
                // Shared by bit-step adds, P+P doubles and discarded dummy adds.
                if (i_op_done) begin
                    if (!discard_q) begin
                        rx_d = i_op_x;
                        ry_d = i_op_y;
                    end
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                oinf_d  = inf_q;
                ox_d    = inf_q ? '0 : rx_q;
                oy_d    = inf_q ? '0 : ry_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (cnt_q == '0) begin
                state_d = S_DONE;
            end else begin
                cnt_d   = cnt_q - 1'b1;
                state_d = S_DBL;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            px_q      <= '0;
            py_q      <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            cnt_q     <= '0;
            inf_q     <= 1'b0;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            dbl_q     <= 1'b0;
            x1_q      <= '0;
            y1_q      <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
            done_q    <= 1'b0;
            oinf_q    <= 1'b0;
            ox_q      <= '0;
            oy_q      <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            px_q      <= px_d;
            py_q      <= py_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            cnt_q     <= cnt_d;
            inf_q     <= inf_d;
            discard_q <= discard_d;
            req_q     <= req_d;
            dbl_q     <= dbl_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            x2_q      <= x2_d;
            y2_q      <= y2_d;
            done_q    <= done_d;
            oinf_q    <= oinf_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
        end
    end

    assign o_busy   = (state_q != S_IDLE) || done_q;
    assign o_done   = done_q;
    assign o_inf    = oinf_q;
    assign o_x      = ox_q;
    assign o_y      = oy_q;
    assign o_op_req = req_q;
    assign o_op_dbl = dbl_q;
    assign o_op_x1  = x1_q;
    assign o_op_y1  = y1_q;
    assign o_op_x2  = x2_q;
    assign o_op_y2  = y2_q;

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Bench for ecc_scalar_mult_ctrl: two instances (plain and constant-time) against a toy
// cyclic group of order N, with an engine model and a scoreboard monitor per instance.
module tb_ecc_scalar_mult_ctrl;

    localparam int unsigned     W      = 20;
    localparam longint unsigned N      = 100003;
    localparam int unsigned     BUDGET = 2000;

    typedef struct packed {
        logic        inf;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [7:0]  nops;
        logic [63:0] ops;   // engine ops in order, 1 = double, 0 = add
    } exp_t;

    logic         clk, rst, start;
    logic [1:0]   mode;
    logic [W-1:0] k, px, py;

    logic         busy [2], done [2], inf [2], op_req [2], op_dbl [2], op_done [2];
    logic [W-1:0] ox [2], oy [2], x1 [2], y1 [2], x2 [2], y2 [2], opx [2], opy [2];

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  eng_lat = 3;
    int unsigned  eng_mode = 0;
    logic [W-1:0] xoff, ypos, yneg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    task automatic chk(input int inst, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s: got %0h required %0h", inst, name, act, exp);
        end
    endtask

    // Group element n*P: x encodes |n| (so P and -P share x), y encodes the sign.
    function automatic void pt_of(input longint unsigned n, output logic [W-1:0] x, output logic [W-1:0] y);
        longint unsigned r, m;
        r = n % N;
        if (r <= N / 2) begin
            m = r;
            y = ypos;
        end else begin
            m = N - r;
            y = yneg;
        end
        x = W'(m + 64'(xoff));
    endfunction

    function automatic longint unsigned idx_of(input logic [W-1:0] x, input logic [W-1:0] y);
        longint unsigned m;
        m = (x >= xoff) ? 64'(x - xoff) : 64'd0;
        if (m > N / 2) m = 0;
        return (y == ypos) ? m : (N - m) % N;
    endfunction

    function automatic void engine_eval(input logic dbl, input logic [W-1:0] ax, input logic [W-1:0] ay,
                                        input logic [W-1:0] bx, input logic [W-1:0] by,
                                        output logic [W-1:0] rx, output logic [W-1:0] ry);
        if (dbl && ax == px && ay == py && eng_mode != 0) begin
            rx = px;
            ry = (eng_mode == 1) ? py : ~py;
        end else if (dbl) begin
            pt_of(2 * idx_of(ax, ay), rx, ry);
        end else begin
            pt_of(idx_of(ax, ay) + idx_of(bx, by), rx, ry);
        end
    endfunction

    function automatic int unsigned klen(input logic [1:0] m);
        case (m)
            2'b00:   return 4;
            2'b01:   return 8;
            2'b10:   return 12;
            default: return 16;
        endcase
    endfunction

    // Reference: result is (k mod 2^len)*P; after the leading one every bit costs a
    // double, then an add for a one bit (or always, in constant-time mode).
    function automatic exp_t model(input logic [W-1:0] kv, input logic [1:0] mv, input bit ct);
        exp_t         e;
        logic [W-1:0] kk, tx, ty;
        int           lead;
        e    = '0;
        kk   = kv & W'((64'd1 << klen(mv)) - 1);
        if (kk == '0) begin
            e.inf = 1'b1;
            return e;
        end
        lead = 0;
        for (int i = 0; i < int'(W); i++) if (kk[i]) lead = i;
        for (int i = lead - 1; i >= 0; i--) begin
            e.ops  = {e.ops[62:0], 1'b1};
            e.nops = e.nops + 8'd1;
            if (kk[i] || ct) begin
                e.ops  = {e.ops[62:0], 1'b0};
                e.nops = e.nops + 8'd1;
            end
        end
        pt_of(64'(kk), tx, ty);
        e.x = tx;
        e.y = ty;
        return e;
    endfunction

    function automatic logic [127:0] outs(input int g);
        return 128'({busy[g], done[g], inf[g], ox[g], oy[g], op_req[g], op_dbl[g], x1[g], y1[g], x2[g], y2[g]});
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        exp_t         q [$];
        logic         pend = 1'b0;
        int unsigned  lat = 0;
        logic [W-1:0] rx, ry;
        logic [7:0]   nops = '0;
        logic [63:0]  ops = '0;

        ecc_scalar_mult_ctrl #(
            .WIDTH(W), .K_LEN0(4), .K_LEN1(8), .K_LEN2(12), .K_LEN3(16), .CONST_TIME(g == 1)
        ) u_dut (
            .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_k(k), .i_x(px), .i_y(py),
            .o_busy(busy[g]), .o_done(done[g]), .o_inf(inf[g]), .o_x(ox[g]), .o_y(oy[g]),
            .o_op_req(op_req[g]), .o_op_dbl(op_dbl[g]),
            .o_op_x1(x1[g]), .o_op_y1(y1[g]), .o_op_x2(x2[g]), .o_op_y2(y2[g]),
            .i_op_done(op_done[g]), .i_op_x(opx[g]), .i_op_y(opy[g])
        );

        initial begin
            op_done[g] = 1'b0;
            opx[g]     = '0;
            opy[g]     = '0;
        end

        // Engine model (ignores reset, so an in-flight op lands late) plus result monitor.
        always @(negedge clk) begin : p_eng_mon
            exp_t e;
            op_done[g] = 1'b0;
            if (pend) begin
                if (lat > 1) begin
                    lat = lat - 1;
                end else begin
                    op_done[g] = 1'b1;
                    opx[g]     = rx;
                    opy[g]     = ry;
                    pend       = 1'b0;
                end
            end else if (rst && op_req[g]) begin
                ops  = {ops[62:0], op_dbl[g]};
                nops = nops + 8'd1;
                engine_eval(op_dbl[g], x1[g], y1[g], x2[g], y2[g], rx, ry);
                pend = 1'b1;
                lat  = eng_lat;
            end
            if (!rst) begin
                ops  = '0;
                nops = '0;
            end else if (done[g]) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst%0d unexpected_done: got o_done=1 required no completion", g);
                end else begin
                    e = q.pop_front();
                    chk(g, "o_inf", 128'(inf[g]), 128'(e.inf));
                    chk(g, "o_x", 128'(ox[g]), 128'(e.x));
                    chk(g, "o_y", 128'(oy[g]), 128'(e.y));
                    chk(g, "op_count", 128'(nops), 128'(e.nops));
                    chk(g, "op_sequence", 128'(ops), 128'(e.ops));
                end
                ops  = '0;
                nops = '0;
            end
        end
    end

    task automatic push_model(input logic [W-1:0] kv, input logic [1:0] mv);
        g_dut[0].q.push_back(model(kv, mv, 1'b0));
        g_dut[1].q.push_back(model(kv, mv, 1'b1));
    endtask

    task automatic push_both(input exp_t e);
        g_dut[0].q.push_back(e);
        g_dut[1].q.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] kv, input logic [1:0] mv, input bit poke, output int unsigned done_cyc);
        int unsigned cyc;
        bit          fin;
        @(posedge clk); #1;
        k     = kv;
        mode  = mv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk(0, "busy_after_start", 128'({busy[0], busy[1]}), 128'(2'b11));
        cyc      = 0;
        fin      = 1'b0;
        done_cyc = 0;
        while (!fin && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
            if (poke) begin
                start = (cyc == 2);
                if (cyc == 2) k = ~kv;
            end
            if (done[0] && done_cyc == 0) done_cyc = cyc;
            if (!busy[0] && !busy[1]) fin = 1'b1;
        end
        start = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: busy still high after %0d cycles, required completion", BUDGET);
        end
    endtask

    initial begin
        int unsigned  cyc;
        bit           stray;
        exp_t         e;
        logic [W-1:0] kv;
        logic [1:0]   mv;

        rst   = 1'b0;
        start = 1'b0;
        mode  = '0;
        k     = '0;
        xoff  = W'($urandom_range(500000, 1));
        ypos  = W'($urandom_range(20'hFFFFF, 1));
        yneg  = ypos;
        while (yneg == ypos) yneg = W'($urandom_range(20'hFFFFF, 1));
        pt_of(64'd1, px, py);

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) chk(g, "reset_outputs", outs(g), '0);
        rst = 1'b1;

        // k = 0: completion exactly K_LEN0+1 cycles after the start edge, at infinity.
        push_model('0, 2'b00);
        run_op('0, 2'b00, 1'b0, cyc);
        chk(0, "k0_done_latency", 128'(cyc), 128'(5));

        push_model(W'(1), 2'b00);
        run_op(W'(1), 2'b00, 1'b0, cyc);

        eng_lat = 3;
        push_model(W'(4'b1011), 2'b00);
        run_op(W'(4'b1011), 2'b00, 1'b0, cyc);

        // Engine claims 2P == P: the controller must fall into the P+P double path.
        eng_mode = 1;
        e        = '0;
        e.x      = px;
        e.y      = py;
        e.nops   = 8'd2;
        e.ops    = 64'b11;
        push_both(e);
        run_op(W'(4'b0011), 2'b00, 1'b0, cyc);

        // Engine claims 2P == -P: adding P must resolve to infinity without a request.
        eng_mode = 2;
        e        = '0;
        e.inf    = 1'b1;
        e.nops   = 8'd1;
        e.ops    = 64'b1;
        push_both(e);
        run_op(W'(4'b0011), 2'b00, 1'b0, cyc);
        eng_mode = 0;

        // Reset while the first double is outstanding, then let the engine answer late.
        eng_lat = 3;
        @(posedge clk); #1;
        k     = W'(4'b1011);
        mode  = 2'b00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (!op_req[0] && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(0, "reset_test_request_seen", 128'(op_req[0]), 128'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) chk(g, "midrun_reset_outputs", outs(g), '0);
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b1;
        stray = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            for (int g = 0; g < 2; g++) if (busy[g] || done[g] || op_req[g]) stray = 1'b1;
        end
        chk(0, "idle_after_stray_done", 128'(stray), '0);

        push_model(W'(4'b1011), 2'b00);
        run_op(W'(4'b1011), 2'b00, 1'b0, cyc);

        for (int r = 0; r < 40; r++) begin
            mv = 2'($urandom_range(3, 0));
            kv = W'($urandom);
            if (r % 5 == 0) kv = W'($urandom_range(15, 0));
            eng_lat = $urandom_range(4, 1);
            push_model(kv, mv);
            run_op(kv, mv, ($urandom_range(1, 0) == 1), cyc);
        end

        chk(0, "leftover_expected", 128'(g_dut[0].q.size()), '0);
        chk(1, "leftover_expected", 128'(g_dut[1].q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
